// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and slave FSM state type
// Contents: APB_ADDR_W, APB_DATA_W, apb_slv_state_t.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_t;

endpackage

// File: rtl/apb_reg_slave_if.sv
// rtl/apb_reg_slave_if.sv - APB bus bundle with master/slave modports
// Signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA (master->slave);
//          PRDATA, PREADY, PSLVERR (slave->master).
interface apb_reg_slave_if;
  import apb_pkg::*;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - word-aligned register window decode
// Ports: paddr (in, byte address); idx (out, register index); err (out, misaligned/out of window).
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter  int                    NUM_REGS  = 8,
  parameter  logic [APB_ADDR_W-1:0] BASE_ADDR = '0,
  localparam int                    IDX_W     = $clog2(NUM_REGS)
) (
  input  logic [APB_ADDR_W-1:0] paddr,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  logic [APB_ADDR_W-1:0] off;

  assign off = paddr - BASE_ADDR;
  assign idx = off[2 +: IDX_W];

  // BASE_ADDR is window-aligned, so off[1:0] equals paddr[1:0] and any set
  // bit above the index field means off >= NUM_REGS*4.
  assign err = (off[1:0] != 2'b00) ||
               (paddr < BASE_ADDR) ||
               (off[APB_ADDR_W-1:IDX_W+2] != '0);

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB register-bank slave with wait states and PSLVERR
// Ports: PCLK, PRESETn (async active-low), bus (apb_reg_slave_if.slave).
// Option: APB_REG_SLAVE_CNT_EN makes the top register a read-only cycle counter.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter  int                    NUM_REGS    = 8,
  parameter  int                    WAIT_STATES = 1,
  parameter  logic [APB_ADDR_W-1:0] BASE_ADDR   = '0,
  localparam int                    IDX_W       = $clog2(NUM_REGS)
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_reg_slave_if.slave   bus
);

  apb_slv_state_t        state, state_nxt;
  logic [3:0]            wcnt;
  logic                  wr_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_DATA_W-1:0] prdata_q;
  logic                  pslverr_q;
  logic [APB_DATA_W-1:0] regs [NUM_REGS];
  logic [APB_DATA_W-1:0] rd_val;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  wr_to_cnt;
  logic                  setup, step, done;

  apb_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_dec (
    .paddr (bus.PADDR),
    .idx   (dec_idx),
    .err   (dec_err)
  );

  assign setup = (state == IDLE) && bus.PSEL && !bus.PENABLE;
  assign step  = (state == ACCESS) && bus.PSEL && bus.PENABLE && (wcnt != 4'd0);
  assign done  = (state == ACCESS) && bus.PSEL && bus.PENABLE && (wcnt == 4'd0);

  assign bus.PREADY  = (state == ACCESS) && (wcnt == 4'd0);
  assign bus.PRDATA  = prdata_q;
  assign bus.PSLVERR = pslverr_q;

`ifdef APB_REG_SLAVE_CNT_EN
  logic [APB_DATA_W-1:0] cyc_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cyc_cnt <= '0;
    else          cyc_cnt <= cyc_cnt + 1'b1;
  end

  // The counter slot is read-only: writes to it are rejected at setup.
  assign wr_to_cnt = bus.PWRITE && (dec_idx == IDX_W'(NUM_REGS - 1));
  assign rd_val    = (idx_q == IDX_W'(NUM_REGS - 1)) ? cyc_cnt : regs[idx_q];
`else
  assign wr_to_cnt = 1'b0;
  assign rd_val    = regs[idx_q];
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (setup) state_nxt = ACCESS;
      ACCESS: if (!bus.PSEL || done) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wcnt      <= 4'd0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (setup) begin
        wr_q    <= bus.PWRITE;
        wdata_q <= bus.PWDATA;
        idx_q   <= dec_idx;
        err_q   <= dec_err || wr_to_cnt;
        wcnt    <= 4'(WAIT_STATES);
      end else if (step) begin
        wcnt <= wcnt - 4'd1;
      end

      // An abort (PSEL low in ACCESS) never reaches here, so nothing commits.
      if (done) begin
        if (wr_q && !err_q) regs[idx_q] <= wdata_q;
        if (!wr_q)          prdata_q    <= err_q ? '0 : rd_val;
        pslverr_q <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - directed table-driven bench for apb_reg_slave
module tb_apb_reg_slave;

  logic PCLK;
  logic PRESETn;

  apb_reg_slave_if b1 ();
  apb_reg_slave_if b0 ();

  // b1: one wait state, window at 0x100; b0: no wait states, window at 0.
  apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0100)) dut1 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (b1)
  );

  apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) dut0 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (b0)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int          w;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input int w, input logic s, input logic e, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (w == 1) begin
      b1.PSEL = s; b1.PENABLE = e; b1.PWRITE = wr; b1.PADDR = a; b1.PWDATA = d;
    end else begin
      b0.PSEL = s; b0.PENABLE = e; b0.PWRITE = wr; b0.PADDR = a; b0.PWDATA = d;
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 1) ? b1.PREADY : b0.PREADY;
  endfunction

  function automatic logic [31:0] rdat(input int w);
    return (w == 1) ? b1.PRDATA : b0.PRDATA;
  endfunction

  function automatic logic serr(input int w);
    return (w == 1) ? b1.PSLVERR : b0.PSLVERR;
  endfunction

  // Entered and left 1 time unit after a rising edge, so calls chain back-to-back.
  task automatic xfer(input int w, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int cyc);
    drive(w, 1'b1, 1'b0, wr, addr, wdata);
    @(posedge PCLK); #1;
    cyc = 1;
    drive(w, 1'b1, 1'b1, wr, addr, wdata);
    while (!rdy(w) && cyc < 40) begin
      @(posedge PCLK); #1;
      cyc++;
    end
    @(posedge PCLK); #1;
    cyc++;
    rdata = rdat(w);
    err   = serr(w);
    drive(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] rd, rd2;
  logic        er;
  int          cyc;

  initial begin
    vecs[0]  = '{1, 1'b1, 32'h104, 32'hA5A5_0003, 32'h0,         1'b0, 3};
    vecs[1]  = '{1, 1'b0, 32'h104, 32'h0,         32'hA5A5_0003, 1'b0, 3};
    vecs[2]  = '{0, 1'b1, 32'h000, 32'h11,        32'h0,         1'b0, 2};
    vecs[3]  = '{0, 1'b0, 32'h000, 32'h0,         32'h11,        1'b0, 2};
    vecs[4]  = '{1, 1'b1, 32'h102, 32'hFF,        32'h0,         1'b1, 3};
    vecs[5]  = '{1, 1'b0, 32'h100, 32'h0,         32'h0,         1'b0, 3};
    vecs[6]  = '{1, 1'b0, 32'h120, 32'h0,         32'h0,         1'b1, 3};
    vecs[7]  = '{1, 1'b0, 32'h0FC, 32'h0,         32'h0,         1'b1, 3};
    vecs[8]  = '{1, 1'b1, 32'h118, 32'h600D,      32'h0,         1'b0, 3};
    vecs[9]  = '{1, 1'b0, 32'h118, 32'h0,         32'h600D,      1'b0, 3};
    vecs[10] = '{0, 1'b0, 32'h020, 32'h0,         32'h0,         1'b1, 2};
    vecs[11] = '{0, 1'b0, 32'h000, 32'h0,         32'h11,        1'b0, 2};

    PRESETn = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_pready1",  {31'h0, b1.PREADY},  32'h0);
    chk("rst_pslverr1", {31'h0, b1.PSLVERR}, 32'h0);
    chk("rst_prdata1",  b1.PRDATA,           32'h0);
    chk("rst_pready0",  {31'h0, b0.PREADY},  32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].w, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, cyc);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_cyc", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_pready_low", i), {31'h0, rdy(vecs[i].w)}, 32'h0);
      if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Abort: drop PSEL during the wait state of a write of 0x55 to reg1.
    drive(1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h55);
    @(posedge PCLK); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h104, 32'h55);
    chk("abort_wait_pready", {31'h0, b1.PREADY}, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge PCLK); #1;
    chk("abort_idle_pready", {31'h0, b1.PREADY}, 32'h0);
    @(posedge PCLK); #1;
    chk("abort_idle_pready2", {31'h0, b1.PREADY}, 32'h0);
    xfer(1, 1'b0, 32'h104, 32'h0, rd, er, cyc);
    chk("abort_readback", rd, 32'hA5A5_0003);
    chk("abort_read_cyc", 32'(cyc), 32'd3);

`ifdef APB_REG_SLAVE_CNT_EN
    xfer(1, 1'b0, 32'h11C, 32'h0, rd, er, cyc);
    chk("cnt_rd1_err", {31'h0, er}, 32'h0);
    repeat (2) @(posedge PCLK);
    #1;
    xfer(1, 1'b0, 32'h11C, 32'h0, rd2, er, cyc);
    chk("cnt_delta", rd2 - rd, 32'd5);
    xfer(1, 1'b1, 32'h11C, 32'h1234, rd2, er, cyc);
    chk("cnt_write_err", {31'h0, er}, 32'h1);
`else
    xfer(1, 1'b1, 32'h11C, 32'h77, rd, er, cyc);
    chk("reg7_write_err", {31'h0, er}, 32'h0);
    xfer(1, 1'b0, 32'h11C, 32'h0, rd, er, cyc);
    chk("reg7_readback", rd, 32'h77);
`endif

    // Reset in the middle of a read of reg1 (PRDATA currently non-zero).
    xfer(1, 1'b0, 32'h104, 32'h0, rd, er, cyc);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    @(posedge PCLK); #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    PRESETn = 1'b0;
    #1;
    chk("midrst_prdata",  b1.PRDATA,           32'h0);
    chk("midrst_pready",  {31'h0, b1.PREADY},  32'h0);
    chk("midrst_pslverr", {31'h0, b1.PSLVERR}, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1, 1'b0, 32'h104, 32'h0, rd, er, cyc);
    chk("postrst_reg1", rd, 32'h0);
    xfer(1, 1'b0, 32'h118, 32'h0, rd, er, cyc);
    chk("postrst_reg6", rd, 32'h0);
    xfer(0, 1'b0, 32'h000, 32'h0, rd, er, cyc);
    chk("postrst_b0_reg0", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB register-bank slave that answers the transfers issued by the team's APB master on the same `apb_interface` bus. It decodes a word-aligned address window and serves reads and writes from `NUM_REGS` 32-bit registers. It inserts a programmable number of wait states and flags out-of-window or misaligned accesses with PSLVERR. It is the downstream end of every APB transaction in the bench and the RTL.

## Interface
Parameters:
- `NUM_REGS`, 8: number of 32-bit registers; must be ≥2 and a power of two.
- `WAIT_STATES`, 1: access-phase cycles with PREADY low before PREADY rises, range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of register 0; aligned to `NUM_REGS*4`.

Ports:
- `PCLK` in 1: single clock; all state updates on the rising edge.
- `PRESETn` in 1: reset, asynchronous assert, active-low.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in 32: byte address.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: transfer completes on this edge.
- `PSLVERR` out 1: transfer error.

## Operation
- FSM states:
  - IDLE: the only state that accepts a new transfer.
  - ACCESS: wait-state count runs and PREADY is driven.
- IDLE → ACCESS on a rising edge with `PSEL && !PENABLE` (setup phase).
  - On that edge, latch PADDR, PWRITE and PWDATA, set `wcnt = WAIT_STATES`, and compute `err`.
  - `PSEL && PENABLE` seen in IDLE is ignored and does not start a transfer.
- In ACCESS, `PREADY = (wcnt == 0)`. On each edge with `PSEL && PENABLE && wcnt != 0`, decrement `wcnt`.
- Completion edge (ACCESS, PSEL, PENABLE, PREADY):
  - Write without `err`: update the register.
  - Read: PRDATA ← register, or 0 when `err`.
  - PSLVERR ← `err`.
  - State → IDLE.
- Abort: PSEL low while in ACCESS → IDLE. Nothing is committed, and PRDATA/PSLVERR are unchanged.
- Decode: `off = PADDR - BASE_ADDR`. `err` is set when any of these holds:
  - `PADDR[1:0] != 0`,
  - `PADDR < BASE_ADDR`,
  - `off >= NUM_REGS*4`.
- Index is `off[2 +: $clog2(NUM_REGS)]`.
- PRDATA and PSLVERR are registered. They hold their last completion value until the next completion, so a master may sample them after the PREADY edge.

## Timing
- Reset values:
  - PRDATA = 0, PREADY = 0, PSLVERR = 0.
  - All registers = 0.
  - State IDLE, `wcnt` = 0.
- Reset mid-transfer aborts immediately with no commit.
- Transfer length:
  - WAIT_STATES = 0: setup edge plus one access edge (2 cycles).
  - WAIT_STATES = N: 2+N cycles.
- PREADY is high for exactly one cycle per completed transfer and is low in IDLE.
- A write is visible to a read whose setup phase starts on the edge after completion. Back-to-back transfers need no idle cycle.

## Configuration
- `APB_REG_SLAVE_CNT_EN` defined:
  - Register `NUM_REGS-1` is a read-only free-running 32-bit cycle counter. It is 0 at reset, increments every PCLK and wraps at 2^32.
  - A read returns the value sampled on the completion edge.
  - A write to it completes with PSLVERR = 1 and does not change it.
- Undefined: register `NUM_REGS-1` is an ordinary R/W register.

## Structure
- Package `apb_pkg`:
  - `APB_ADDR_W = 32`, `APB_DATA_W = 32`.
  - `typedef enum logic {IDLE, ACCESS} apb_slv_state_t`.
- Sub-module `apb_addr_decode` (combinational):
  - Inputs: PADDR, BASE_ADDR, NUM_REGS.
  - Outputs: index and `err`.
- FSM, wait counter, register array and optional counter live in `apb_reg_slave`.

## Test plan
- Reset: PRESETn low mid-transfer → PREADY/PSLVERR/PRDATA = 0 at once; a later read of any register returns 0.
- Write/read, WAIT_STATES = 1: write 0xA5A5_0003 to BASE+0x04, then read BASE+0x04.
  - PREADY rises on the 2nd access edge each time.
  - PRDATA = 0xA5A5_0003, PSLVERR = 0.
- WAIT_STATES = 0, back-to-back: write 0x11 to BASE+0x00, then immediately read BASE+0x00 → read returns 0x11, each transfer takes 2 cycles.
- Errors:
  - Write 0xFF to BASE+0x02 → PSLVERR = 1, no register changes.
  - Read BASE+NUM_REGS*4 → PSLVERR = 1, PRDATA = 0.
- Abort: drop PSEL during a wait state of a write of 0x55 → FSM returns to IDLE; a subsequent read returns the old value.
- `APB_REG_SLAVE_CNT_EN`:
  - Two reads of BASE+(NUM_REGS-1)*4 five cycles apart differ by 5.
  - A write to that address → PSLVERR = 1.
